// File: rtl/softmax_pkg.sv
// softmax_pkg: shared FSM states, Newton-Raphson seed constants and the probability tolerance.
package softmax_pkg;
   typedef enum logic [2:0] {IDLE, CHECK, NORM, ITER, EMIT} state_t;
   localparam real NR_SEED_A = 48.0 / 17.0;
   localparam real NR_SEED_B = 32.0 / 17.0;
   localparam real PROB_TOL  = 1e-9;
endpackage

// File: rtl/recip_nr_unit.sv
// recip_nr_unit: reciprocal of a positive real by power-of-two range scaling plus Newton-Raphson.
// o_done pulses for one enabled cycle; o_err alongside it means the input needed too many shifts.
module recip_nr_unit
   import softmax_pkg::*;
#(
   parameter int NR_ITERS  = 4,
   parameter int MAX_SHIFT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_start,
   input  real  i_sum,
   output logic o_done,
   output logic o_err,
   output logic o_iter,
   output real  o_recip
);
   localparam int SW = $clog2(MAX_SHIFT + 1);
   localparam int CW = $clog2(NR_ITERS + 1);

   state_t          r_phase;
   real             r_s;
   real             r_x;
   real             r_scale;
   logic [SW-1:0]   r_shift;
   logic [CW-1:0]   r_it;

   assign o_iter  = r_phase == ITER;
   assign o_recip = r_x * r_scale;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_phase <= IDLE;
         r_s     <= 0.0;
         r_x     <= 0.0;
         r_scale <= 1.0;
         r_shift <= '0;
         r_it    <= '0;
         o_done  <= 1'b0;
         o_err   <= 1'b0;
      end else if (i_en) begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         if (i_start) begin
            r_phase <= NORM;
            r_s     <= i_sum;
            r_scale <= 1.0;
            r_shift <= '0;
         end else if (r_phase == NORM) begin
            if (r_s >= 1.0 || r_s < 0.5) begin
               if (r_shift == SW'(MAX_SHIFT)) begin
                  o_err   <= 1'b1;
                  o_done  <= 1'b1;
                  r_phase <= IDLE;
               end else begin
                  r_s     <= (r_s >= 1.0) ? r_s * 0.5 : r_s * 2.0;
                  r_scale <= (r_s >= 1.0) ? r_scale * 0.5 : r_scale * 2.0;
                  r_shift <= r_shift + 1'b1;
               end
            end else begin
               // linear seed is within 1/17 relative error over [0.5,1)
               r_x     <= NR_SEED_A - NR_SEED_B * r_s;
               r_it    <= '0;
               r_phase <= ITER;
            end
         end else if (r_phase == ITER) begin
            r_x <= r_x * (2.0 - r_s * r_x);
            if (r_it == CW'(NR_ITERS - 1)) begin
               o_done  <= 1'b1;
               r_phase <= IDLE;
            end else begin
               r_it <= r_it + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/softmax_normalizer.sv
// softmax_normalizer: captures an exp vector with its sum and streams exp[i]/sum one element per handshake.
// Errors still emit N zeros so downstream framing is preserved.
module softmax_normalizer
   import softmax_pkg::*;
#(
   parameter int N         = 4,
   parameter int NR_ITERS  = 4,
   parameter int MAX_SHIFT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 doProcess,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  real                  exp_in [0:N-1],
   input  real                  exp_sum_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output real                  prob_out,
   output logic [$clog2(N)-1:0] prob_idx,
   output logic                 prob_last,
   output logic                 err,
   output logic                 busy
);
   localparam int IW = $clog2(N);

   state_t          r_state;
   real             r_buf [0:N-1];
   real             r_sum;
   real             r_recip;
   logic            w_start;
   logic            w_done;
   logic            w_nr_err;
   logic            w_iter;
   logic            w_enter;
   logic            w_enter_err;
   real             w_nr_recip;
   real             w_recip;
   logic [IW-1:0]   w_next_idx;

   assign w_start     = doProcess && r_state == CHECK && !(r_sum <= 0.0);
   assign w_enter_err = (r_state == CHECK && r_sum <= 0.0)
                     || ((r_state == NORM || r_state == ITER) && w_done && w_nr_err);
   assign w_enter     = w_enter_err || ((r_state == NORM || r_state == ITER) && w_done);
   assign w_recip     = w_enter_err ? 0.0 : w_nr_recip;
   assign w_next_idx  = prob_idx + 1'b1;
   assign in_ready    = r_state == IDLE;
   assign busy        = r_state != IDLE;

   recip_nr_unit #(.NR_ITERS(NR_ITERS), .MAX_SHIFT(MAX_SHIFT)) u_recip (
      .clk     (clk),
      .reset   (reset),
      .i_en    (doProcess),
      .i_start (w_start),
      .i_sum   (r_sum),
      .o_done  (w_done),
      .o_err   (w_nr_err),
      .o_iter  (w_iter),
      .o_recip (w_nr_recip)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_sum     <= 0.0;
         r_recip   <= 0.0;
         for (int i = 0; i < N; i++) r_buf[i] <= 0.0;
         out_valid <= 1'b0;
         prob_out  <= 0.0;
         prob_idx  <= '0;
         prob_last <= 1'b0;
         err       <= 1'b0;
      end else if (doProcess) begin
         if (w_enter) begin
            r_state   <= EMIT;
            r_recip   <= w_recip;
            err       <= w_enter_err;
            out_valid <= 1'b1;
            prob_out  <= r_buf[0] * w_recip;
            prob_idx  <= '0;
            prob_last <= N == 1;
         end else begin
            case (r_state)
               IDLE: if (in_valid) begin
                  for (int i = 0; i < N; i++) r_buf[i] <= exp_in[i];
                  r_sum   <= exp_sum_in;
                  err     <= 1'b0;
                  r_state <= CHECK;
               end
               CHECK: r_state <= NORM;
               NORM:  if (w_iter) r_state <= ITER;
               EMIT:  if (out_ready) begin
                  if (prob_last) begin
                     out_valid <= 1'b0;
                     prob_last <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     prob_idx  <= w_next_idx;
                     prob_out  <= r_buf[w_next_idx] * r_recip;
                     prob_last <= w_next_idx == IW'(N - 1);
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_softmax_normalizer.sv
// tb_softmax_normalizer: directed vectors with hand-computed probabilities, latencies and error framing.
module tb_softmax_normalizer;
   import softmax_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       doProcess = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   real        exp_in [0:3];
   real        exp_sum_in = 0.0;
   logic       in_ready;
   logic       out_valid;
   logic       prob_last;
   logic       err;
   logic       busy;
   real        prob_out;
   logic [1:0] prob_idx;
   real        xp [4];
   int         n_chk = 0;
   int         n_pass = 0;

   softmax_normalizer #(.N(4), .NR_ITERS(4), .MAX_SHIFT(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .doProcess  (doProcess),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exp_in     (exp_in),
      .exp_sum_in (exp_sum_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .prob_out   (prob_out),
      .prob_idx   (prob_idx),
      .prob_last  (prob_last),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input real got, input real want);
      real d = got - want;
      real m = want < 0.0 ? -want : want;
      n_chk++;
      if ((d < 0.0 ? -d : d) <= PROB_TOL * m) n_pass++;
      else $display("FAIL %s: got %g, want %g", tag, got, want);
   endtask

   task automatic send(input real e0, input real e1, input real e2, input real e3, input real s);
      int g = 0;
      while (!in_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) chk("in_ready_wait", 0.0, 1.0);
      exp_in[0] = e0; exp_in[1] = e1; exp_in[2] = e2; exp_in[3] = e3;
      exp_sum_in = s;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int want);
      int c = 0;
      while (!out_valid && c < 300) begin
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      if (want >= 0) chk(tag, real'(c), real'(want));
      else if (!out_valid) chk({tag, "_timeout"}, 0.0, 1.0);
   endtask

   task automatic collect(input bit rnd, input bit e_err);
      int k = 0;
      int g = 0;
      while (k < 4 && g < 400) begin
         out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (out_valid) begin
            chk(out_ready ? "prob" : "stall_prob", prob_out, xp[k]);
            chk(out_ready ? "idx" : "stall_idx", real'(prob_idx), real'(k));
            if (out_ready) begin
               chk("last", real'(prob_last), real'(k == 3));
               chk("err", real'(err), real'(e_err));
               k++;
            end
         end
         @(posedge clk);
         @(negedge clk);
         g++;
      end
      if (k < 4) chk("collect_timeout", real'(k), 4.0);
      out_ready = 1'b1;
      chk("out_valid_after", real'(out_valid), 0.0);
      chk("in_ready_after", real'(in_ready), 1.0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, real'(in_ready), 1.0);
      chk({tag, "_out_valid"}, real'(out_valid), 0.0);
      chk({tag, "_prob"}, prob_out, 0.0);
      chk({tag, "_idx"}, real'(prob_idx), 0.0);
      chk({tag, "_last"}, real'(prob_last), 0.0);
      chk({tag, "_err"}, real'(err), 0.0);
      chk({tag, "_busy"}, real'(busy), 0.0);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 4; i++) exp_in[i] = 0.0;
      #2 reset = 1'b1;
      #1 chk_reset_vals("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: basic vector, sum=8 needs four halvings
      xp = '{0.125, 0.25, 0.375, 0.25};
      send(1.0, 2.0, 3.0, 2.0, 8.0);
      chk("busy", real'(busy), 1.0);
      chk("in_ready_busy", real'(in_ready), 0.0);
      wait_out("lat_sum8", 11);
      collect(1'b0, 1'b0);

      // 2: sum=2 then an in-range sum needing no shifts
      xp = '{0.25, 0.25, 0.25, 0.25};
      send(0.5, 0.5, 0.5, 0.5, 2.0);
      wait_out("lat_sum2", 9);
      collect(1'b0, 1'b0);
      xp = '{2.0 / 3.0, 2.0 / 3.0, 2.0 / 3.0, 2.0 / 3.0};
      send(0.5, 0.5, 0.5, 0.5, 0.75);
      wait_out("lat_sum075", 7);
      collect(1'b0, 1'b0);

      // 3: non-positive sums
      xp = '{0.0, 0.0, 0.0, 0.0};
      send(1.0, 2.0, 3.0, 2.0, 0.0);
      wait_out("lat_zero", 1);
      collect(1'b0, 1'b1);
      send(1.0, 2.0, 3.0, 2.0, -1.0);
      wait_out("lat_neg", 1);
      collect(1'b0, 1'b1);
      chk("err_sticky", real'(err), 1.0);

      // 4: out-of-range sum, then a large in-range sum
      send(1.0, 2.0, 3.0, 2.0, 1e30);
      wait_out("big", -1);
      collect(1'b0, 1'b1);
      xp = '{0.25, 0.5, 0.125, 0.125};
      send(256.0, 512.0, 128.0, 128.0, 1024.0);
      chk("err_cleared", real'(err), 0.0);
      wait_out("lat_sum1024", 18);
      collect(1'b0, 1'b0);

      // 5: random backpressure
      xp = '{0.4, 0.3, 0.2, 0.1};
      send(4.0, 3.0, 2.0, 1.0, 10.0);
      wait_out("stall", -1);
      collect(1'b1, 1'b0);

      // 6a: reset while iterating aborts with no later output
      send(1.0, 2.0, 3.0, 2.0, 8.0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 chk_reset_vals("rst_iter");
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("no_partial", real'(seen), 0.0);

      // 6b: reset during emission at idx 2
      out_ready = 1'b0;
      send(4.0, 3.0, 2.0, 1.0, 10.0);
      wait_out("emit2", -1);
      out_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("emit2_idx", real'(prob_idx), 2.0);
      chk("emit2_prob", prob_out, 0.2);
      reset = 1'b1;
      #1 chk_reset_vals("rst_emit");
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;

      // 6c: doProcess freeze mid-normalisation
      xp = '{0.25, 0.5, 0.125, 0.125};
      send(256.0, 512.0, 128.0, 128.0, 1024.0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      doProcess = 1'b0;
      repeat (5) @(negedge clk);
      chk("freeze_busy", real'(busy), 1.0);
      chk("freeze_valid", real'(out_valid), 0.0);
      doProcess = 1'b1;
      wait_out("lat_freeze", 14);
      collect(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
